// File: rtl/rr_mux5_arbiter.sv
// Round-robin arbiter for five requesters sharing one 5:1 single-bit mux.
// Grants are burst-limited to N_BURST cycles and hand over with no idle bubble.
module rr_mux5_arbiter #(
    parameter int N_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    input  logic [4:0] i,
    output logic [2:0] sel,
    output logic [4:0] gnt,
    output logic       busy,
    output logic       y
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [2:0] BURST_MAX = 3'(N_BURST);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic [4:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] scan_idx;
    logic       release_now;
    logic       take_grant;

    // Circular scan from ptr; 4-bit sum with explicit wrap keeps indices in 0..4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scan_idx = {1'b0, ptr_q} + 4'(k);
            if (scan_idx >= 4'd5) begin
                scan_idx = scan_idx - 4'd5;
            end
            if (!win_found && req[scan_idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[2:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        take_grant  = 1'b0;
        release_now = !req[sel_q] || (cnt_q == BURST_MAX);

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    take_grant = 1'b1;
                end
            end
            S_GRANT: begin
                if (!release_now) begin
                    cnt_d = cnt_q + 3'd1;
                end else if (win_found) begin
                    take_grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 5'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 5'd0;
                busy_d  = 1'b0;
                cnt_d   = 3'd0;
            end
        endcase

        // A release with pending requests re-grants on the same edge.
        if (take_grant) begin
            state_d = S_GRANT;
            sel_d   = win_idx;
            gnt_d   = 5'd1 << win_idx;
            busy_d  = 1'b1;
            cnt_d   = 3'd1;
            ptr_d   = (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 3'd0;
            sel_q   <= 3'd0;
            gnt_q   <= 5'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign y    = busy_q ? i[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux5_arbiter.sv
// Directed bench for rr_mux5_arbiter (N_BURST = 4) with hand-computed grant sequences.
module tb_rr_mux5_arbiter;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [4:0] i;
    logic [2:0] sel;
    logic [4:0] gnt;
    logic       busy;
    logic       y;

    int checks;
    int errors;

    rr_mux5_arbiter #(.N_BURST(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .i    (i),
        .sel  (sel),
        .gnt  (gnt),
        .busy (busy),
        .y    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel must never leave 0..4 while out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (sel <= 3'd4) else begin
                errors++;
                $error("[TB] FAIL sel_range observed=%0d expected=0..4", sel);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] r, input logic [4:0] d);
        req = r;
        i   = d;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] eg, input logic [2:0] es,
                               input logic eb, input logic ey);
        checks++;
        assert (gnt === eg) else begin
            errors++;
            $error("[TB] FAIL %s gnt observed=%b expected=%b", tag, gnt, eg);
        end
        checks++;
        assert (sel === es) else begin
            errors++;
            $error("[TB] FAIL %s sel observed=%0d expected=%0d", tag, sel, es);
        end
        checks++;
        assert (busy === eb) else begin
            errors++;
            $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, eb);
        end
        checks++;
        assert (y === ey) else begin
            errors++;
            $error("[TB] FAIL %s y observed=%b expected=%b", tag, y, ey);
        end
    endtask

    initial begin
        logic [4:0] data_pat;
        logic [2:0] exp_sel;

        checks   = 0;
        errors   = 0;
        data_pat = 5'b10101;
        rst      = 1'b1;
        applyStimulus(5'b00000, 5'b00000);
        #3;
        checkOutput("reset_init", 5'b00000, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        step();
        checkOutput("idle_no_req", 5'b00000, 3'd0, 1'b0, 1'b0);

        // Single requester 2 held 10 cycles: re-granted every burst, never a gap.
        applyStimulus(5'b00100, data_pat);
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput("single_req2", 5'b00100, 3'd2, 1'b1, 1'b1);
        end
        applyStimulus(5'b00000, data_pat);
        step();
        checkOutput("single_drop", 5'b00000, 3'd2, 1'b0, 1'b0);

        // ptr is now 3; requester 2 still wins the scan 3,4,0,1,2.
        applyStimulus(5'b00100, data_pat);
        step();
        checkOutput("pre_reset_grant", 5'b00100, 3'd2, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_grant", 5'b00000, 3'd0, 1'b0, 1'b0);
        step();
        checkOutput("reset_held", 5'b00000, 3'd0, 1'b0, 1'b0);
        applyStimulus(5'b11111, data_pat);
        rst = 1'b0;

        // Full contention from ptr 0: 0,1,2,3,4,0 each for 4 cycles.
        for (int s = 0; s < 6; s++) begin
            exp_sel = 3'(s % 5);
            for (int c = 0; c < 4; c++) begin
                step();
                checkOutput("contention", 5'd1 << exp_sel, exp_sel, 1'b1, data_pat[exp_sel]);
            end
        end

        // Early release: requester 1 granted (ptr was 1), drops after 2 cycles.
        applyStimulus(5'b01010, data_pat);
        step();
        checkOutput("early_g1_c1", 5'b00010, 3'd1, 1'b1, 1'b0);
        step();
        checkOutput("early_g1_c2", 5'b00010, 3'd1, 1'b1, 1'b0);
        applyStimulus(5'b01000, data_pat);
        step();
        checkOutput("early_to_g3", 5'b01000, 3'd3, 1'b1, 1'b0);
        applyStimulus(5'b01010, data_pat);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("early_g3_hold", 5'b01000, 3'd3, 1'b1, 1'b0);
        end
        step();
        checkOutput("early_g3_burst_end", 5'b00010, 3'd1, 1'b1, 1'b0);

        // Wrap-around: requester 4 granted, ptr must wrap to 0.
        applyStimulus(5'b10000, data_pat);
        step();
        checkOutput("wrap_g4", 5'b10000, 3'd4, 1'b1, 1'b1);
        applyStimulus(5'b10001, data_pat);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("wrap_g4_hold", 5'b10000, 3'd4, 1'b1, 1'b1);
        end
        step();
        checkOutput("wrap_to_g0", 5'b00001, 3'd0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("wrap_g0_hold", 5'b00001, 3'd0, 1'b1, 1'b1);
        end
        step();
        checkOutput("wrap_back_g4", 5'b10000, 3'd4, 1'b1, 1'b1);

        // Mid-grant data toggle reaches y with no clock edge.
        applyStimulus(5'b10001, 5'b00101);
        #1;
        checkOutput("mux_toggle_lo", 5'b10000, 3'd4, 1'b1, 1'b0);
        applyStimulus(5'b10001, 5'b10101);
        #1;
        checkOutput("mux_toggle_hi", 5'b10000, 3'd4, 1'b1, 1'b1);

        applyStimulus(5'b00000, data_pat);
        step();
        checkOutput("final_idle", 5'b00000, 3'd4, 1'b0, 1'b0);
        applyStimulus(5'b00000, 5'b11111);
        #1;
        checkOutput("idle_y_masked", 5'b00000, 3'd4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
